// File: rtl/bidir_pkg.sv
// Shared types and constants for the half-duplex pad direction controller.
package bidir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_RX   = 2'd2,
        ST_TURN = 2'd3
    } state_e;

    localparam int CNT_W    = 4;
    localparam int TURN_MIN = 1;
    localparam int TURN_MAX = (1 << CNT_W) - 1;

    // The turnaround counter is loaded with TURN-1, so TURN must fit in CNT_W bits and be non-zero.
    function automatic bit turn_in_range(input int turn);
        return (turn >= TURN_MIN) && (turn <= TURN_MAX);
    endfunction

endpackage

// File: rtl/half_duplex_port_ctrl_if.sv
// Local-side handshake bundle: transmit stream in, received words and bus direction out.
interface half_duplex_port_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             rx_req;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             dir;

    modport master (
        output tx_valid, tx_data, rx_req,
        input  tx_ready, rx_valid, rx_data, dir
    );

    modport slave (
        input  tx_valid, tx_data, rx_req,
        output tx_ready, rx_valid, rx_data, dir
    );
endinterface

// File: rtl/bidir_pad.sv
// Tristate driver for the shared line: drives d when oe is set, otherwise releases to high-Z.
module bidir_pad #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             oe,
    output logic [WIDTH-1:0] q,
    inout  wire  [WIDTH-1:0] pad
);

    assign pad = oe ? d : {WIDTH{1'bz}};
    assign q   = pad;

endmodule

// File: rtl/half_duplex_port_ctrl.sv
// Half-duplex direction controller: arbitrates a local TX stream against remote RX requests
// and enforces a released-bus turnaround gap on every ownership change.
module half_duplex_port_ctrl
    import bidir_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TURN  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    half_duplex_port_ctrl_if.slave bus,
    inout  wire  [WIDTH-1:0]       pad
);

    if (!turn_in_range(TURN)) begin : g_turn_check
        $error("half_duplex_port_ctrl: TURN out of range 1..15");
    end

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN - 1);

    state_e             r_state;
    state_e             w_next;
    logic               r_dir;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_rx_valid;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_sample;
    logic [WIDTH-1:0]   w_pad_q;

    bidir_pad #(.WIDTH(WIDTH)) u_pad (
        .d   (r_out),
        .oe  (r_dir),
        .q   (w_pad_q),
        .pad (pad)
    );

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_sample = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.rx_req) begin
                    w_sample = 1'b1;
                    w_next   = ST_RX;
                end else if (bus.tx_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_TX;
                end
            end
            ST_TX: begin
                if (bus.tx_valid && !bus.rx_req) begin
                    w_accept = 1'b1;
                end else begin
                    w_next = ST_TURN;
                end
            end
            ST_RX: begin
                if (bus.rx_req) begin
                    w_sample = 1'b1;
                end else begin
                    w_next = ST_TURN;
                end
            end
            ST_TURN: begin
                if (r_cnt == '0) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // NOTE: the reset is asynchronous so r_dir drops, and the pad releases, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dir      <= 1'b0;
            r_out      <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_next;
            r_dir      <= (w_next == ST_TX);
            r_rx_valid <= w_sample;
            if (w_accept) begin
                r_out <= bus.tx_data;
            end
            if (w_sample) begin
                r_rx_data <= w_pad_q;
            end
            // Load on entry to TURN, count down while inside it.
            if ((r_state != ST_TURN) && (w_next == ST_TURN)) begin
                r_cnt <= TURN_LOAD;
            end else if ((r_state == ST_TURN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.tx_ready = !rst && !bus.rx_req && ((r_state == ST_IDLE) || (r_state == ST_TX));
    assign bus.dir      = r_dir;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;

endmodule

// File: tb/tb_half_duplex_port_ctrl.sv
// Directed bench for half_duplex_port_ctrl (WIDTH=8, TURN=2) with a polite remote pad driver.
module tb_half_duplex_port_ctrl;

    localparam int WIDTH = 8;
    localparam int TURN  = 2;

    logic             clk;
    logic             rst;
    logic             rem_oe;
    logic [WIDTH-1:0] rem_d;
    wire  [WIDTH-1:0] pad;

    int checks = 0;
    int errors = 0;

    half_duplex_port_ctrl_if #(.WIDTH(WIDTH)) bus ();

    half_duplex_port_ctrl #(.WIDTH(WIDTH), .TURN(TURN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .pad (pad)
    );

    // Remote end of the line; while it drives, the controller must have released the pad.
    assign pad = rem_oe ? rem_d : {WIDTH{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rem_oe) check("contention_dir", {15'd0, bus.dir}, 16'd0);
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h11;
        bus.rx_req   = 1'b0;
        rem_oe       = 1'b1;
        rem_d        = 8'hC3;
        #1 rst = 1'b1;
        #2;
        check("rst_dir",      {15'd0, bus.dir},      16'd0);
        check("rst_tx_ready", {15'd0, bus.tx_ready}, 16'd0);
        check("rst_rx_valid", {15'd0, bus.rx_valid}, 16'd0);
        check("rst_rx_data",  {8'd0, bus.rx_data},   16'h00);
        check("rst_pad_rel",  {8'd0, pad},           16'hC3);
        tick();
        tick();
        check("rst_hold_ready", {15'd0, bus.tx_ready}, 16'd0);

        // Release reset with a word waiting.
        rst    = 1'b0;
        rem_oe = 1'b0;
        #1;
        check("idle_tx_ready", {15'd0, bus.tx_ready}, 16'd1);
        check("idle_dir",      {15'd0, bus.dir},      16'd0);

        // Burst 0x11, 0x22, 0x33.
        tick();
        check("tx0_dir", {15'd0, bus.dir}, 16'd1);
        check("tx0_pad", {8'd0, pad},      16'h11);
        check("tx0_rdy", {15'd0, bus.tx_ready}, 16'd1);
        bus.tx_data = 8'h22;
        tick();
        check("tx1_pad", {8'd0, pad}, 16'h22);
        bus.tx_data = 8'h33;
        tick();
        check("tx2_pad", {8'd0, pad},      16'h33);
        check("tx2_dir", {15'd0, bus.dir}, 16'd1);
        bus.tx_valid = 1'b0;

        // TX -> TURN (2 cycles) -> IDLE.
        tick();
        check("turn0_dir", {15'd0, bus.dir},      16'd0);
        check("turn0_rdy", {15'd0, bus.tx_ready}, 16'd0);
        rem_oe = 1'b1;
        rem_d  = 8'h3C;
        #1;
        check("turn0_pad_rel", {8'd0, pad}, 16'h3C);
        tick();
        check("turn1_dir", {15'd0, bus.dir},      16'd0);
        check("turn1_rdy", {15'd0, bus.tx_ready}, 16'd0);
        tick();
        check("idle_after_turn", {15'd0, bus.tx_ready}, 16'd1);

        // Remote sends 0xA5 then 0x5A.
        bus.rx_req = 1'b1;
        rem_d      = 8'hA5;
        #1;
        check("rxreq_blocks_ready", {15'd0, bus.tx_ready}, 16'd0);
        tick();
        check("rx0_valid", {15'd0, bus.rx_valid}, 16'd1);
        check("rx0_data",  {8'd0, bus.rx_data},   16'hA5);
        check("rx0_dir",   {15'd0, bus.dir},      16'd0);
        rem_d = 8'h5A;
        tick();
        check("rx1_valid", {15'd0, bus.rx_valid}, 16'd1);
        check("rx1_data",  {8'd0, bus.rx_data},   16'h5A);
        bus.rx_req = 1'b0;
        rem_oe     = 1'b0;
        tick();
        check("rx_end_valid", {15'd0, bus.rx_valid}, 16'd0);
        check("rx_end_data",  {8'd0, bus.rx_data},   16'h5A);
        check("rx_end_rdy",   {15'd0, bus.tx_ready}, 16'd0);
        tick();
        tick();
        check("rx_idle_rdy", {15'd0, bus.tx_ready}, 16'd1);

        // Simultaneous request: RX wins.
        bus.rx_req   = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h44;
        rem_oe       = 1'b1;
        rem_d        = 8'h96;
        #1;
        check("both_rdy", {15'd0, bus.tx_ready}, 16'd0);
        tick();
        check("both_dir",    {15'd0, bus.dir},      16'd0);
        check("both_rxv",    {15'd0, bus.rx_valid}, 16'd1);
        check("both_rxdata", {8'd0, bus.rx_data},   16'h96);
        bus.rx_req = 1'b0;
        rem_oe     = 1'b0;
        #1;
        check("both_rx_rdy", {15'd0, bus.tx_ready}, 16'd0);
        tick();
        check("both_turn0_rdy", {15'd0, bus.tx_ready}, 16'd0);
        check("both_turn0_dir", {15'd0, bus.dir},      16'd0);
        tick();
        check("both_turn1_rdy", {15'd0, bus.tx_ready}, 16'd0);
        tick();
        check("both_idle_rdy", {15'd0, bus.tx_ready}, 16'd1);
        check("both_idle_dir", {15'd0, bus.dir},      16'd0);
        tick();
        check("late_tx_dir", {15'd0, bus.dir}, 16'd1);
        check("late_tx_pad", {8'd0, pad},      16'h44);

        // rx_req rises mid-burst.
        bus.tx_data = 8'h55;
        tick();
        check("burst_pad", {8'd0, pad}, 16'h55);
        bus.rx_req  = 1'b1;
        bus.tx_data = 8'h66;
        #1;
        check("rise_rdy", {15'd0, bus.tx_ready}, 16'd0);
        tick();
        check("rise_turn0_dir", {15'd0, bus.dir}, 16'd0);
        rem_oe = 1'b1;
        rem_d  = 8'hE1;
        tick();
        check("rise_turn1_dir", {15'd0, bus.dir},      16'd0);
        check("rise_turn1_rxv", {15'd0, bus.rx_valid}, 16'd0);
        tick();
        check("rise_idle_dir", {15'd0, bus.dir},      16'd0);
        check("rise_idle_rxv", {15'd0, bus.rx_valid}, 16'd0);
        tick();
        check("rise_rx_rxv",  {15'd0, bus.rx_valid}, 16'd1);
        check("rise_rx_data", {8'd0, bus.rx_data},   16'hE1);

        // Leave RX with a word pending: dir may rise only TURN+1 edges later.
        bus.rx_req  = 1'b0;
        rem_oe      = 1'b0;
        bus.tx_data = 8'h77;
        tick();
        check("leave0_dir", {15'd0, bus.dir}, 16'd0);
        tick();
        check("leave1_dir", {15'd0, bus.dir}, 16'd0);
        tick();
        check("leave2_dir", {15'd0, bus.dir}, 16'd0);
        tick();
        check("resume_dir", {15'd0, bus.dir}, 16'd1);
        check("resume_pad", {8'd0, pad},      16'h77);

        // Asynchronous reset mid-TX releases the pad before any clock edge.
        #2;
        rst    = 1'b1;
        rem_oe = 1'b1;
        rem_d  = 8'h88;
        #1;
        check("arst_pad_rel", {8'd0, pad},           16'h88);
        check("arst_dir",     {15'd0, bus.dir},      16'd0);
        check("arst_rxv",     {15'd0, bus.rx_valid}, 16'd0);
        check("arst_rdy",     {15'd0, bus.tx_ready}, 16'd0);
        tick();
        rst          = 1'b0;
        rem_oe       = 1'b0;
        bus.tx_valid = 1'b0;
        #1;
        check("post_rst_rdy", {15'd0, bus.tx_ready}, 16'd1);
        check("post_rst_dir", {15'd0, bus.dir},      16'd0);
        tick();
        check("post_rst_idle_dir", {15'd0, bus.dir}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
